mac_seq: RTL and testbench
==========================

# mac_seq

Dot-product sequencer for the fixed-point `mac` datapath. On `start`, it fetches `len` operand pairs from two single-port coefficient/sample memories and drives the MAC's `en`/`clr` so the first pair restarts accumulation. It then captures the final accumulated value and presents it on a valid/ready result port. It sits between the filter/transform control logic and one `mac` instance.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: memory address width.
- `LEN_WIDTH`, 11: length field width; must satisfy len ≤ 2^ADDR_WIDTH.
- `OUT_WIDTH`, 43: MAC output width, matching the `mac` instance's `OUT_WIDTH`.

Ports (clk, rst first):
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: job request; sampled only in IDLE.
- `abort`  in  1: synchronous cancel of the current job.
- `len`  in  LEN_WIDTH: number of operand pairs; sampled with start.
- `x_base`, `y_base`  in  ADDR_WIDTH each: start addresses; sampled with start.
- `x_addr`, `y_addr`  out  ADDR_WIDTH each: memory read addresses.
- `rd_en`  out  1: memory read strobe; data returns exactly 1 cycle later.
- `mac_en`  out  1: drives `mac.en`.
- `mac_clr`  out  1: drives `mac.clr`.
- `mac_out`  in  OUT_WIDTH: from `mac.out` (combinational acc+product).
- `result`  out  OUT_WIDTH: captured dot product.
- `result_valid`  out  1: result available.
- `result_ready`  in  1: consumer accepts.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- **IDLE**
  - start with len>0: latch len and bases, clear the index counter, go to FETCH.
  - start with len=0: load `result`=0 and go to HOLD.
- **FETCH**
  - Each cycle: rd_en=1, x_addr=x_base+idx, y_addr=y_base+idx, idx increments.
  - Address addition wraps modulo 2^ADDR_WIDTH.
  - When idx reaches len-1 (the last issue), go to DRAIN.
- **Issue pipeline** (1-stage shadow register): valid, first, last, one cycle behind the read issue.
  - mac_en = shadow valid.
  - mac_clr = shadow first; asserted only together with mac_en.
- **DRAIN**: one cycle in which the last pair is presented. With shadow last and mac_en high, register `result`<=mac_out and go to HOLD.
- **HOLD**
  - result_valid=1; `result` stays stable until the handshake.
  - result_valid && result_ready: go to IDLE next cycle.
  - A start in the same cycle is ignored (start is accepted in IDLE only).
- **Abort**
  - In FETCH or DRAIN: go to IDLE next cycle, clear the shadow valid, drive no mac_en for the aborted job, and produce no result.
  - In HOLD: drop the result and go to IDLE.
  - In IDLE: no effect.
  - Abort and start together in IDLE: abort wins; the job is not started.
- start, len and the bases are don't-care outside IDLE.

## Timing
- Reset values: state=IDLE, idx=0, all outputs 0 (rd_en, mac_en, mac_clr, result, result_valid, busy, x_addr, y_addr).
- start accepted at cycle 0. Then:
  - reads at cycles 1..N;
  - mac_en at cycles 2..N+1, with mac_clr at cycle 2 only;
  - result captured at the end of cycle N+1;
  - result_valid from cycle N+2.
- Start-to-valid latency is N+2 cycles; len=0 gives valid at cycle 1.
- Minimum start-to-start interval: N+3 cycles plus the handshake wait.
- The N=1 path (FETCH→DRAIN after one cycle) must work: mac_en and mac_clr are both high in the same cycle.
- Reset mid-job returns everything to reset values immediately; an in-flight memory read is discarded.

## Configuration
- `MAC_SEQ_PERF_EN` defined:
  - Adds output `cycles` (32 bits): counts clk edges with busy=1 in the current job.
  - Cleared on job start; frozen in HOLD and IDLE.
  - Wraps at 2^32; reset value 0.
- `MAC_SEQ_PERF_EN` undefined: the `cycles` port and counter are absent. All other behaviour is identical.

## Structure
- Package `mac_pkg`:
  - state enum for IDLE/FETCH/DRAIN/HOLD;
  - default width constants shared with `mac` (43/32 fixed-point).
- One sub-module, `mac_seq_addr_gen`: holds the idx counter, produces base+idx for both memories, and flags last. Instantiated once.
- The MAC itself is instantiated by the parent, not inside mac_seq.

## Test plan
- **Basic dot product:** len=4, x={1.0,2.0,3.0,4.0}, y={0.5,0.5,0.5,0.5} in Q11.32 → result=5.0 (0x5_0000_0000); valid at cycle 6; mac_clr exactly once at cycle 2.
- **Back-to-back jobs:** two jobs without a MAC reset, second job len=2, x={1,1}, y={3,3} → result=6.0. Checks that clr restarts accumulation and nothing leaks from the previous job.
- **Length edge cases:**
  - len=0 → result=0 at cycle 1, rd_en never asserted;
  - len=1, x=2, y=−1.5 → result=−3.0, mac_en and mac_clr coincident.
- **Back-pressure:** hold result_ready=0 for 10 cycles → result_valid stays high, result stable, start pulses ignored and busy=1. Release → IDLE next cycle.
- **Abort and address wrap:** abort at FETCH cycle 2 of a len=8 job → at most 2 mac_en pulses, then IDLE, no result_valid. x_base=2^ADDR_WIDTH−2 with len=4 → addresses wrap to 0,1.
- **Async reset:** rst low mid-FETCH → all outputs 0 immediately. With `MAC_SEQ_PERF_EN`, len=4 gives cycles=6 at HOLD entry.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac datapath and its dot-product sequencer.
//   - seq_state_e : sequencer FSM states (IDLE, FETCH, DRAIN, HOLD)
//   - MAC_OUT_WIDTH / MAC_FRAC_BITS : default accumulator width and fraction
//     bits of the fixed-point mac (Q11.32)
//   - SEQ_ADDR_WIDTH / SEQ_LEN_WIDTH : default memory address and job length widths
package mac_pkg;

  localparam int MAC_OUT_WIDTH  = 43;
  localparam int MAC_FRAC_BITS  = 32;
  localparam int SEQ_ADDR_WIDTH = 10;
  localparam int SEQ_LEN_WIDTH  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_seq_if.sv
// mac_seq_if: result channel of the dot-product sequencer (valid/ready).
//   result       : captured dot product, OUT_WIDTH bits
//   result_valid : result available, held until accepted
//   result_ready : consumer accepts
// Modports: master = sequencer side, slave = consumer side.
interface mac_seq_if
  import mac_pkg::*;
#(
  parameter int OUT_WIDTH = MAC_OUT_WIDTH
) ();

  logic [OUT_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// mac_seq_addr_gen: operand index counter for mac_seq.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   load             : latch len and both bases, clear the index
//   step             : advance the index by one
//   len              : number of operand pairs (latched on load)
//   x_base, y_base   : memory start addresses (latched on load)
//   x_addr, y_addr   : base + index, wrapping modulo 2^ADDR_WIDTH
//   first, last      : index is the first / the final pair of the job
module mac_seq_addr_gen
  import mac_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int LEN_WIDTH  = SEQ_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] y_base,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  first,
  output logic                  last
);

  logic [LEN_WIDTH-1:0]  idx;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0] x_base_q;
  logic [ADDR_WIDTH-1:0] y_base_q;

  // Job parameters are captured once at job start so that the requester may
  // change len/bases while the job runs; the index then walks 0..len-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      len_q    <= '0;
      x_base_q <= '0;
      y_base_q <= '0;
    end else if (load) begin
      idx      <= '0;
      len_q    <= len;
      x_base_q <= x_base;
      y_base_q <= y_base;
    end else if (step) begin
      idx <= idx + LEN_WIDTH'(1);
    end
  end

  // The index never exceeds 2^ADDR_WIDTH-1 while issuing, so its low bits are
  // the offset; the sum drops the carry, giving modulo wrap of the address.
  assign x_addr = x_base_q + idx[ADDR_WIDTH-1:0];
  assign y_addr = y_base_q + idx[ADDR_WIDTH-1:0];
  assign first  = (idx == '0);
  assign last   = (idx == (len_q - LEN_WIDTH'(1)));

endmodule

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer driving one external fixed-point mac.
// On start it reads len operand pairs from two single-port memories, drives
// mac en/clr so the first pair restarts accumulation, captures the final
// accumulator value and offers it on a valid/ready result channel.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   start, abort     : job request (IDLE only) / synchronous cancel
//   len, x_base,
//   y_base           : job parameters, sampled with start
//   x_addr, y_addr,
//   rd_en            : memory read port, data returns one cycle after rd_en
//   mac_en, mac_clr  : mac controls (clr only ever together with en)
//   mac_out          : mac combinational acc+product
//   res              : result channel (mac_seq_if.master)
//   busy             : high in any state other than IDLE
//   cycles           : busy-cycle count of the current job (MAC_SEQ_PERF_EN only)
// Build option: define MAC_SEQ_PERF_EN to add the cycles performance counter.
module mac_seq
  import mac_pkg::*;
#(
  parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
  parameter int LEN_WIDTH  = SEQ_LEN_WIDTH,
  parameter int OUT_WIDTH  = MAC_OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] y_base,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  rd_en,
  output logic                  mac_en,
  output logic                  mac_clr,
  input  logic [OUT_WIDTH-1:0]  mac_out,
  mac_seq_if.master             res,
  output logic                  busy
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]           cycles
`endif
);

  seq_state_e state;
  logic       sh_valid;
  logic       sh_first;
  logic       sh_last;
  logic       ag_first;
  logic       ag_last;
  logic       job_load;
  logic       idx_step;
  logic       job_accept;

  // A job is accepted only from IDLE and only when abort is not also raised;
  // len=0 is accepted too but bypasses the address generator.
  assign job_accept = (state == IDLE) && start && !abort;
  assign job_load   = job_accept && (len != '0);
  assign idx_step   = (state == FETCH) && !abort;

  mac_seq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (job_load),
    .step   (idx_step),
    .len    (len),
    .x_base (x_base),
    .y_base (y_base),
    .x_addr (x_addr),
    .y_addr (y_addr),
    .first  (ag_first),
    .last   (ag_last)
  );

  // The shadow register trails the read issue by one cycle, lining the mac
  // controls up with the memory data; clr is gated so it never fires alone.
  assign mac_en  = sh_valid;
  assign mac_clr = sh_valid & sh_first;

  // Main sequencer FSM. All control outputs are registered here so they
  // change only on clock edges; the shadow flags default to empty each cycle
  // and are refilled only while FETCH issues a read that is not aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      rd_en            <= 1'b0;
      busy             <= 1'b0;
      sh_valid         <= 1'b0;
      sh_first         <= 1'b0;
      sh_last          <= 1'b0;
      res.result       <= '0;
      res.result_valid <= 1'b0;
    end else begin
      sh_valid <= 1'b0;
      sh_first <= 1'b0;
      sh_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (job_accept) begin
            busy <= 1'b1;
            if (len == '0) begin
              res.result       <= '0;
              res.result_valid <= 1'b1;
              state            <= HOLD;
            end else begin
              rd_en <= 1'b1;
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            rd_en <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            sh_valid <= 1'b1;
            sh_first <= ag_first;
            sh_last  <= ag_last;
            if (ag_last) begin
              rd_en <= 1'b0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sh_valid && sh_last) begin
            res.result       <= mac_out;
            res.result_valid <= 1'b1;
            state            <= HOLD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          if (abort || res.result_ready) begin
            res.result_valid <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end
        default: begin
          rd_en            <= 1'b0;
          busy             <= 1'b0;
          res.result_valid <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_PERF_EN
  // The accepting edge is the first busy edge of a job, so on HOLD entry the
  // count equals the start-to-valid latency; it is frozen in HOLD and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles <= '0;
    end else if (job_accept) begin
      cycles <= 32'd1;
    end else if ((state == FETCH) || (state == DRAIN)) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: self-checking bench for mac_seq with a behavioural mac and two
// synchronous-read memories. Expected results are pushed into a queue when a
// job is issued; a forked monitor pops and compares on every result handshake.
module tb_mac_seq;
  import mac_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [10:0] len;
  logic [9:0]  x_base;
  logic [9:0]  y_base;
  logic [9:0]  x_addr;
  logic [9:0]  y_addr;
  logic        rd_en;
  logic        mac_en;
  logic        mac_clr;
  logic        busy;
  logic [42:0] mac_out;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] cycles;
`endif

  mac_seq_if #(.OUT_WIDTH(43)) res_if ();

  mac_seq #(
    .ADDR_WIDTH (10),
    .LEN_WIDTH  (11),
    .OUT_WIDTH  (43)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .len     (len),
    .x_base  (x_base),
    .y_base  (y_base),
    .x_addr  (x_addr),
    .y_addr  (y_addr),
    .rd_en   (rd_en),
    .mac_en  (mac_en),
    .mac_clr (mac_clr),
    .mac_out (mac_out),
    .res     (res_if),
    .busy    (busy)
`ifdef MAC_SEQ_PERF_EN
    ,
    .cycles  (cycles)
`endif
  );

  // Operand memories hold Q7.16 samples; products land in Q11.32.
  logic [23:0] xmem [0:1023];
  logic [23:0] ymem [0:1023];
  logic [23:0] xd = '0;
  logic [23:0] yd = '0;
  logic [42:0] acc = '0;
  logic signed [42:0] xs;
  logic signed [42:0] ys;
  logic signed [42:0] prod;

  logic [42:0] expq [$];
  int          total_checks = 0;
  int          bad_checks   = 0;
  int          addr_log [0:15];
  int          v_cyc, rd_cnt, en_cnt, clr_cnt, clr_cyc, both_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memories: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      xd <= xmem[x_addr];
      yd <= ymem[y_addr];
    end
  end

  // Behavioural mac: out = (clr ? 0 : acc) + x*y, accumulate when enabled.
  assign xs      = {{19{xd[23]}}, xd};
  assign ys      = {{19{yd[23]}}, yd};
  assign prod    = xs * ys;
  assign mac_out = (mac_clr ? 43'd0 : acc) + prod;

  always @(posedge clk) begin
    if (mac_en) acc <= mac_out;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic monitorResults();
    logic [42:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && res_if.result_valid && res_if.result_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected result", 64'(res_if.result), 64'hDEAD);
        end else begin
          e = expq.pop_front();
          checkOutput("result", 64'(res_if.result), 64'(e));
        end
      end
    end
  endtask

  // Must be called at a falling edge with the DUT idle; returns mid-cycle 1.
  task automatic applyStimulus(input int n, input int xb, input int yb,
                               input logic [42:0] expv, input bit push);
    start  = 1'b1;
    len    = n[10:0];
    x_base = xb[9:0];
    y_base = yb[9:0];
    if (push) expq.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runJob(input int n, input int xb, input int yb,
                        input logic [42:0] expv);
    v_cyc = -1; rd_cnt = 0; en_cnt = 0; clr_cnt = 0; clr_cyc = -1; both_cnt = 0;
    applyStimulus(n, xb, yb, expv, 1'b1);
    for (int k = 1; k <= n + 20; k++) begin
      if (rd_en) begin
        if (rd_cnt < 16) addr_log[rd_cnt] = int'(x_addr);
        rd_cnt++;
      end
      if (mac_en) en_cnt++;
      if (mac_clr) begin
        clr_cnt++;
        clr_cyc = k;
      end
      if (mac_en && mac_clr) both_cnt++;
      if (res_if.result_valid) begin
        v_cyc = k;
        break;
      end
      @(negedge clk);
    end
    if (v_cyc < 0) checkOutput("result_valid timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " rd_en"}, 64'(rd_en), 64'd0);
    checkOutput({tag, " mac_en"}, 64'(mac_en), 64'd0);
    checkOutput({tag, " mac_clr"}, 64'(mac_clr), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " result_valid"}, 64'(res_if.result_valid), 64'd0);
    checkOutput({tag, " result"}, 64'(res_if.result), 64'd0);
    checkOutput({tag, " x_addr"}, 64'(x_addr), 64'd0);
    checkOutput({tag, " y_addr"}, 64'(y_addr), 64'd0);
`ifdef MAC_SEQ_PERF_EN
    checkOutput({tag, " cycles"}, 64'(cycles), 64'd0);
`endif
  endtask

  // Hard stop if anything hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int viol;
    int en_seen;
    int valid_seen;
    int wrap_exp [0:3];
    wrap_exp = '{1022, 1023, 0, 1};

    rst    = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    len    = '0;
    x_base = '0;
    y_base = '0;
    res_if.result_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    xmem[0] = 24'h010000; xmem[1] = 24'h020000;
    xmem[2] = 24'h030000; xmem[3] = 24'h040000;
    for (int i = 100; i < 104; i++) ymem[i] = 24'h008000;
    xmem[10] = 24'h010000; xmem[11] = 24'h010000;
    ymem[110] = 24'h030000; ymem[111] = 24'h030000;
    xmem[20] = 24'h020000; ymem[120] = 24'hFE8000;
    xmem[1022] = 24'h010000; xmem[1023] = 24'h010000;
    for (int i = 200; i < 204; i++) ymem[i] = 24'h008000;

    fork
      monitorResults();
    join_none

    $display("[TB] power-on reset");
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] basic dot product len=4");
    runJob(4, 0, 100, 43'h5_0000_0000);
    checkOutput("basic valid cycle", 64'(v_cyc), 64'd6);
    checkOutput("basic clr count", 64'(clr_cnt), 64'd1);
    checkOutput("basic clr cycle", 64'(clr_cyc), 64'd2);
    checkOutput("basic en count", 64'(en_cnt), 64'd4);
    checkOutput("basic rd count", 64'(rd_cnt), 64'd4);
`ifdef MAC_SEQ_PERF_EN
    checkOutput("perf cycles at hold", 64'(cycles), 64'd6);
`endif
    @(negedge clk);
    checkOutput("basic back to idle", 64'(busy), 64'd0);

    $display("[TB] back-to-back job len=2");
    runJob(2, 10, 110, 43'h6_0000_0000);
    checkOutput("b2b valid cycle", 64'(v_cyc), 64'd4);
    checkOutput("b2b clr count", 64'(clr_cnt), 64'd1);
    @(negedge clk);

    $display("[TB] len=0");
    runJob(0, 0, 100, 43'h0);
    checkOutput("len0 valid cycle", 64'(v_cyc), 64'd1);
    checkOutput("len0 rd count", 64'(rd_cnt), 64'd0);
    checkOutput("len0 en count", 64'(en_cnt), 64'd0);
    @(negedge clk);

    $display("[TB] len=1");
    runJob(1, 20, 120, 43'h7FD_0000_0000);
    checkOutput("len1 valid cycle", 64'(v_cyc), 64'd3);
    checkOutput("len1 en and clr together", 64'(both_cnt), 64'd1);
    checkOutput("len1 clr cycle", 64'(clr_cyc), 64'd2);
    @(negedge clk);

    $display("[TB] back-pressure");
    res_if.result_ready = 1'b0;
    runJob(3, 0, 100, 43'h3_0000_0000);
    checkOutput("bp valid cycle", 64'(v_cyc), 64'd5);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_if.result_valid !== 1'b1) viol++;
      if (busy !== 1'b1) viol++;
      if (rd_en !== 1'b0) viol++;
      if (res_if.result !== 43'h3_0000_0000) viol++;
      start  = ((i % 3) == 0);
      len    = 11'd2;
      x_base = 10'd0;
    end
    @(negedge clk);
    start = 1'b0;
    if (res_if.result_valid !== 1'b1) viol++;
    if (rd_en !== 1'b0) viol++;
    checkOutput("bp hold violations", 64'(viol), 64'd0);
    res_if.result_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp idle after release", 64'(busy), 64'd0);
    checkOutput("bp valid dropped", 64'(res_if.result_valid), 64'd0);

    $display("[TB] abort during fetch");
    applyStimulus(8, 0, 100, 43'h0, 1'b0);
    en_seen = 0;
    valid_seen = 0;
    if (mac_en) en_seen++;
    @(negedge clk);
    abort = 1'b1;
    if (mac_en) en_seen++;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort to idle", 64'(busy), 64'd0);
    for (int i = 0; i < 12; i++) begin
      if (mac_en) en_seen++;
      if (res_if.result_valid) valid_seen++;
      @(negedge clk);
    end
    checkOutput("abort mac_en at most 2", 64'(en_seen <= 2), 64'd1);
    checkOutput("abort no result", 64'(valid_seen), 64'd0);

    $display("[TB] abort with start in idle");
    start = 1'b1;
    abort = 1'b1;
    len   = 11'd4;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort+start busy", 64'(busy), 64'd0);
    checkOutput("abort+start rd_en", 64'(rd_en), 64'd0);
    @(negedge clk);

    $display("[TB] address wrap");
    runJob(4, 1022, 200, 43'h2_8000_0000);
    checkOutput("wrap valid cycle", 64'(v_cyc), 64'd6);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("wrap x_addr[%0d]", i), 64'(addr_log[i]), 64'(wrap_exp[i]));
    @(negedge clk);

    $display("[TB] async reset mid-fetch");
    applyStimulus(8, 0, 100, 43'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    runJob(2, 10, 110, 43'h6_0000_0000);
    checkOutput("post-reset valid cycle", 64'(v_cyc), 64'd4);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
